// File: rtl/kbd_playback_ctrl.sv
// Keyboard playback controller: edge-qualified ASCII keys drive play/pause, direction and restart of the flash reader.
// Define KBD_SPEED_CTRL_EN to enable the saturating speed_div keys (KEY_FASTER / KEY_SLOWER).
module kbd_playback_ctrl #(
    parameter int unsigned SPEED_W       = 16,
    parameter int unsigned SPEED_DEFAULT = 1136,
    parameter int unsigned SPEED_MIN     = 568,
    parameter int unsigned SPEED_MAX     = 2272,
    parameter int unsigned SPEED_STEP    = 64,
    parameter logic [7:0]  KEY_PLAY      = 8'h45,
    parameter logic [7:0]  KEY_PAUSE     = 8'h44,
    parameter logic [7:0]  KEY_FWD       = 8'h46,
    parameter logic [7:0]  KEY_BWD       = 8'h42,
    parameter logic [7:0]  KEY_RST       = 8'h52,
    parameter logic [7:0]  KEY_FASTER    = 8'h55,
    parameter logic [7:0]  KEY_SLOWER    = 8'h53
) (
    input  logic               inclk,
    input  logic               reset,
    input  logic               kbd_data_ready,
    input  logic [7:0]         kbd_received_ascii_code,
    input  logic               flash_read_finished,
    output logic               direction,
    output logic               start_read_flash,
    output logic               restart,
    output logic [SPEED_W-1:0] speed_div,
    output logic               unknown_key
);

`ifdef KBD_SPEED_CTRL_EN
    localparam bit SPEED_EN = 1'b1;
`else
    localparam bit SPEED_EN = 1'b0;
`endif

    localparam logic [SPEED_W:0] STEP_X = (SPEED_W+1)'(SPEED_STEP);
    localparam logic [SPEED_W:0] MIN_X  = (SPEED_W+1)'(SPEED_MIN);
    localparam logic [SPEED_W:0] MAX_X  = (SPEED_W+1)'(SPEED_MAX);

    typedef enum logic [1:0] {ST_PAUSE, ST_PLAY, ST_RST_WAIT} state_e;

    state_e             state_q, state_d;
    logic               ready_q;
    logic               run_mem_q, run_mem_d;
    logic               direction_q, direction_d;
    logic               unknown_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W:0]   speed_dn, speed_up;
    logic               accept;

    assign accept   = kbd_data_ready & ~ready_q;
    // One extra bit so a step past either limit is seen instead of wrapping.
    assign speed_dn = {1'b0, speed_q} - STEP_X;
    assign speed_up = {1'b0, speed_q} + STEP_X;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        run_mem_d   = run_mem_q;
        direction_d = direction_q;
        speed_d     = speed_q;
        unknown_d   = 1'b0;
        if (accept) begin
            case (kbd_received_ascii_code)
                KEY_PLAY: begin
                    if (state_q == ST_RST_WAIT) run_mem_d = 1'b1;
                    else                        state_d   = ST_PLAY;
                end
                KEY_PAUSE: begin
                    if (state_q == ST_RST_WAIT) run_mem_d = 1'b0;
                    else                        state_d   = ST_PAUSE;
                end
                KEY_FWD: direction_d = 1'b1;
                KEY_BWD: direction_d = 1'b0;
                KEY_RST: begin
                    if (state_q != ST_RST_WAIT) begin
                        state_d   = ST_RST_WAIT;
                        run_mem_d = (state_q == ST_PLAY);
                    end
                end
                KEY_FASTER: begin
                    if (!SPEED_EN)                             unknown_d = 1'b1;
                    else if (speed_dn[SPEED_W] || speed_dn < MIN_X) speed_d = SPEED_W'(SPEED_MIN);
                    else                                       speed_d   = speed_dn[SPEED_W-1:0];
                end
                KEY_SLOWER: begin
                    if (!SPEED_EN)             unknown_d = 1'b1;
                    else if (speed_up > MAX_X) speed_d   = SPEED_W'(SPEED_MAX);
                    else                       speed_d   = speed_up[SPEED_W-1:0];
                end
                default: unknown_d = 1'b1;
            endcase
        end
        // A key arriving with the finish pulse has already updated run_mem_d.
        if (state_q == ST_RST_WAIT && flash_read_finished)
            state_d = run_mem_d ? ST_PLAY : ST_PAUSE;
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_PAUSE;
            ready_q          <= 1'b0;
            run_mem_q        <= 1'b0;
            direction_q      <= 1'b1;
            speed_q          <= SPEED_W'(SPEED_DEFAULT);
            start_read_flash <= 1'b0;
            restart          <= 1'b0;
            unknown_key      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q          <= state_d;
            ready_q          <= kbd_data_ready;
            run_mem_q        <= run_mem_d;
            direction_q      <= direction_d;
            speed_q          <= speed_d;
            start_read_flash <= (state_d != ST_PAUSE);
            restart          <= (state_d == ST_RST_WAIT);
            unknown_key      <= unknown_d;
        end
    end

    assign direction = direction_q;
    assign speed_div = speed_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Self-checking bench for kbd_playback_ctrl: directed scenarios plus random keys against a behavioural model.
module tb_kbd_playback_ctrl;

    localparam logic [7:0] K_E = 8'h45, K_D = 8'h44, K_F = 8'h46, K_B = 8'h42;
    localparam logic [7:0] K_R = 8'h52, K_U = 8'h55, K_S = 8'h53, K_Z = 8'h5A;

`ifdef KBD_SPEED_CTRL_EN
    localparam bit SPEED_EN = 1'b1;
`else
    localparam bit SPEED_EN = 1'b0;
`endif

    logic        inclk = 1'b0;
    logic        reset;
    logic        kbd_data_ready;
    logic [7:0]  kbd_received_ascii_code;
    logic        flash_read_finished;
    logic        direction;
    logic        start_read_flash;
    logic        restart;
    logic [15:0] speed_div;
    logic        unknown_key;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: playing / waiting-for-reposition / resume-after-wait.
    bit m_play, m_wait, m_resume, m_dir, m_unk, m_prev_rdy;
    int m_speed;

    kbd_playback_ctrl dut (
        .inclk                  (inclk),
        .reset                  (reset),
        .kbd_data_ready         (kbd_data_ready),
        .kbd_received_ascii_code(kbd_received_ascii_code),
        .flash_read_finished    (flash_read_finished),
        .direction              (direction),
        .start_read_flash       (start_read_flash),
        .restart                (restart),
        .speed_div              (speed_div),
        .unknown_key            (unknown_key)
    );

    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_wait = 0; m_resume = 0; m_dir = 1; m_unk = 0; m_prev_rdy = 0;
        m_speed = 1136;
    endtask

    task automatic model_edge(input bit rdy, input logic [7:0] code, input bit fin);
        bit was_wait;
        was_wait = m_wait;
        m_unk = 0;
        if (rdy && !m_prev_rdy) begin
            if (code == K_E) begin
                if (m_wait) m_resume = 1; else m_play = 1;
            end else if (code == K_D) begin
                if (m_wait) m_resume = 0; else m_play = 0;
            end else if (code == K_F) m_dir = 1;
            else if (code == K_B) m_dir = 0;
            else if (code == K_R) begin
                if (!m_wait) begin m_resume = m_play; m_wait = 1; end
            end else if (code == K_U && SPEED_EN) m_speed = (m_speed - 64 < 568) ? 568 : m_speed - 64;
            else if (code == K_S && SPEED_EN) m_speed = (m_speed + 64 > 2272) ? 2272 : m_speed + 64;
            else m_unk = 1;
        end
        if (was_wait && fin) begin
            m_wait = 0;
            m_play = m_resume;
        end
        m_prev_rdy = rdy;
    endtask

    task automatic compare_all();
        check("start_read_flash", start_read_flash, m_play || m_wait);
        check("restart", restart, m_wait);
        check("direction", direction, m_dir);
        check("speed_div", speed_div, m_speed);
        check("unknown_key", unknown_key, m_unk);
    endtask

    task automatic step(input bit rdy, input logic [7:0] code, input bit fin);
        @(negedge inclk);
        kbd_data_ready = rdy; kbd_received_ascii_code = code; flash_read_finished = fin;
        @(posedge inclk);
        model_edge(rdy, code, fin);
        #1;
        compare_all();
    endtask

    task automatic press(input logic [7:0] code);
        step(1, code, 0);
        step(0, code, 0);
    endtask

    task automatic do_reset();
        @(negedge inclk);
        reset = 1; kbd_data_ready = 0; kbd_received_ascii_code = 8'h00; flash_read_finished = 0;
        #1;
        model_reset();
        check("rst_state", {start_read_flash, restart, direction, unknown_key}, 4'b0010);
        check("rst_speed", speed_div, 1136);
        @(negedge inclk);
        reset = 0;
    endtask

    initial begin
        logic [7:0] codes [9];
        codes = '{K_E, K_D, K_F, K_B, K_R, K_U, K_S, K_Z, 8'h00};
        model_reset();
        reset = 1; kbd_data_ready = 0; kbd_received_ascii_code = 8'h00; flash_read_finished = 0;
        #2;
        check("por_start", start_read_flash, 0);
        check("por_restart", restart, 0);
        do_reset();

        // Play from reset.
        step(1, K_E, 0);
        check("play_start", start_read_flash, 1);
        check("play_restart", restart, 0);
        check("play_dir", direction, 1);
        step(0, K_E, 0);

        // Backward, restart, finish resumes play.
        press(K_B);
        press(K_R);
        check("rw_restart", restart, 1);
        check("rw_dir", direction, 0);
        step(0, 8'h00, 1);
        check("rw_exit_restart", restart, 0);
        check("rw_exit_start", start_read_flash, 1);
        step(0, 8'h00, 0);

        // From pause: restart, play while waiting, pause coincident with finish.
        press(K_D);
        press(K_R);
        press(K_E);
        step(1, K_D, 1);
        check("coinc_start", start_read_flash, 0);
        check("coinc_restart", restart, 0);
        step(0, K_D, 0);

        // Held ready gives one command.
        press(K_E);
        repeat (5) step(1, K_D, 0);
        repeat (3) step(1, K_E, 0);
        step(0, K_E, 0);
        check("hold_start", start_read_flash, 0);

        // Speed keys from default speed.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, K_U, 0);
            if (SPEED_EN) check("faster", speed_div, (1136 - 64 * (i + 1) < 568) ? 568 : 1136 - 64 * (i + 1));
            else          check("faster_unk", unknown_key, 1);
            step(0, K_U, 0);
        end
        check("speed_low", speed_div, SPEED_EN ? 568 : 1136);
        repeat (30) press(K_S);
        check("speed_high", speed_div, SPEED_EN ? 2272 : 1136);

        // Unmapped key pulses once.
        press(K_E);
        step(1, K_Z, 0);
        check("z_unk", unknown_key, 1);
        check("z_start", start_read_flash, 1);
        step(0, K_Z, 0);
        check("z_unk_clr", unknown_key, 0);

        // Asynchronous reset while waiting for reposition.
        press(K_R);
        check("mid_restart_pre", restart, 1);
        #3 reset = 1;
        #1;
        check("mid_restart_async", restart, 0);
        check("mid_start_async", start_read_flash, 0);
        model_reset();
        @(negedge inclk);
        reset = 0;
        step(0, 8'h00, 1);

        // Random keys, ready and finish pulses.
        for (int i = 0; i < 1500; i++) begin
            int idx;
            logic [7:0] code;
            idx  = $urandom_range(0, 9);
            code = (idx == 9) ? 8'($urandom) : codes[idx];
            step($urandom_range(0, 4) < 3, code, $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
